// File: rtl/dmem_seq.sv
// Y86-64 memory-stage sequencer: splits each 64-bit load/store into eight
// little-endian byte transfers on a byte-wide synchronous RAM, stalling the datapath.
module dmem_seq #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic        err,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {IDLE, WR, RD, RLAST, DONE} state_t;
    typedef enum logic [1:0] {CL_NONE, CL_WR, CL_RD} cls_t;

    // Highest base whose eight bytes still fit; compared unsigned so huge bases cannot wrap.
    localparam logic [63:0] LIMIT = 64'(MEM_BYTES - 8);

    state_t      state, state_nx;
    cls_t        cls;
    logic [63:0] base_sel;
    logic        range_err;
    logic [2:0]  cnt;
    logic [63:0] base_q;
    logic [63:0] wbuf_q;
    logic [63:0] rbuf_q;
    logic        err_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cls      = CL_NONE;
        base_sel = valE;
        unique case (icode)
            4'h4, 4'h8, 4'hA: cls = CL_WR;
            4'h5:             cls = CL_RD;
            4'h9, 4'hB: begin
                cls      = CL_RD;
                base_sel = valA;
            end
            default:          cls = CL_NONE;
        endcase
        range_err = (base_sel > LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cls == CL_NONE || range_err) state_nx = DONE;
                    else if (cls == CL_WR)           state_nx = WR;
                    else                             state_nx = RD;
                end
            end
            WR:      if (cnt == 3'd7) state_nx = DONE;
            RD:      if (cnt == 3'd7) state_nx = RLAST;
            RLAST:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the assembled-read buffer is a plain register, so it is reset along with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            base_q <= 64'd0;
            wbuf_q <= 64'd0;
            rbuf_q <= 64'd0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_sel;
                        wbuf_q <= wdata;
                        cnt    <= 3'd0;
                        err_q  <= (cls != CL_NONE) && range_err;
                    end
                end
                WR: cnt <= cnt + 3'd1;
                RD: begin
                    // RAM data lags the read enable by one cycle, so byte cnt-1 arrives now.
                    if (cnt != 3'd0) rbuf_q[{cnt - 3'd1, 3'b000} +: 8] <= mem_rdata;
                    cnt <= cnt + 3'd1;
                end
                RLAST:   rbuf_q[63:56] <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        err       = err_q;
        rdata     = rbuf_q;
        mem_we    = (state == WR);
        mem_re    = (state == RD);
        mem_addr  = base_q + {61'd0, cnt};
        mem_wdata = (state == WR) ? wbuf_q[{cnt, 3'b000} +: 8] : 8'h00;
    end

endmodule
